// File: rtl/screen_frame_streamer_if.sv
// -----------------------------------------------------------------------------
// screen_frame_streamer_if
//   Pixel stream bundle between the frame streamer (master) and a pixel sink
//   (slave, e.g. display driver or test monitor).
//   pix_valid : pixel data and markers are valid          (master -> slave)
//   pix_ready : sink accepts the current pixel              (slave  -> master)
//   pix_data  : pixel colour {r,g,b}, r in the MSBs         (master -> slave)
//   pix_x     : column of the current pixel                 (master -> slave)
//   pix_y     : row of the current pixel                    (master -> slave)
//   pix_sof   : start of frame, high with pixel (0,0)       (master -> slave)
//   pix_eol   : end of line, high with x = SCR_W-1          (master -> slave)
//   pix_eof   : end of frame, high with the last pixel      (master -> slave)
// -----------------------------------------------------------------------------
interface screen_frame_streamer_if #(
  parameter int SCR_W = 30,
  parameter int SCR_H = 30,
  parameter int PIX_W = 24
);
  localparam int XW = (SCR_W > 1) ? $clog2(SCR_W) : 1;
  localparam int YW = (SCR_H > 1) ? $clog2(SCR_H) : 1;

  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic [XW-1:0]    pix_x;
  logic [YW-1:0]    pix_y;
  logic             pix_sof;
  logic             pix_eol;
  logic             pix_eof;

  modport master (
    output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/screen_frame_streamer.sv
// -----------------------------------------------------------------------------
// screen_frame_streamer
//   Snapshots the flat RGB screen bus into a shadow buffer on a frame request
//   and streams the pixels in raster order (y outer, x inner) over a
//   valid/ready handshake, tagged with position and frame markers.
//
// Ports
//   clk        : clock
//   reset      : synchronous, active-high reset
//   screen_in  : flat frame, pixel (x,y) at element x*SCR_H+y
//   frame_req  : request to capture and stream one frame
//   busy       : high from capture until the last pixel is accepted
//   frame_done : one-cycle pulse after the last pixel is accepted
//   drop_count : frame requests ignored while busy, saturates at 255
//   pix        : pixel stream (master side of screen_frame_streamer_if)
// -----------------------------------------------------------------------------
module screen_frame_streamer #(
  parameter int SCR_W = 30,
  parameter int SCR_H = 30,
  parameter int PIX_W = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SCR_W*SCR_H*PIX_W-1:0] screen_in,
  input  logic                         frame_req,
  output logic                         busy,
  output logic                         frame_done,
  output logic [7:0]                   drop_count,
  screen_frame_streamer_if.master      pix
);

  localparam int XW   = (SCR_W > 1) ? $clog2(SCR_W) : 1;
  localparam int YW   = (SCR_H > 1) ? $clog2(SCR_H) : 1;
  localparam int NPIX = SCR_W * SCR_H;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  // One spare bit so x*SCR_H+y can never wrap before the range check.
  localparam int IW   = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       drop_q;
  logic             valid_q;
  logic [PIX_W-1:0] data_q;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic             sof_q;
  logic             eol_q;
  logic             eof_q;

  // Shadow copy of the screen, element order identical to screen_in.
  logic [PIX_W-1:0] shadow_q [NPIX];

  logic             capture_s;
  logic             last_x_s;
  logic [XW-1:0]    nx_d;
  logic [YW-1:0]    ny_d;
  logic [IW-1:0]    idx_d;
  logic             idx_ok_s;
  logic             neol_d;
  logic             neof_d;
  logic [PIX_W-1:0] npix_d;

  // Next raster position, its buffer index and the markers it will carry.
  always_comb begin
    capture_s = (state_q == S_IDLE) && frame_req;
    last_x_s  = (x_q == XW'(SCR_W - 1));
    if (last_x_s) begin
      nx_d = '0;
      ny_d = y_q + YW'(1);
    end else begin
      nx_d = x_q + XW'(1);
      ny_d = y_q;
    end
    // Screen storage is column-major while the stream is row-major.
    idx_d    = (IW'(nx_d) * IW'(SCR_H)) + IW'(ny_d);
    idx_ok_s = (idx_d < IW'(NPIX));
    if (idx_ok_s) begin
      npix_d = shadow_q[idx_d[AW-1:0]];
    end else begin
      npix_d = '0;
    end
    neol_d = (nx_d == XW'(SCR_W - 1));
    neof_d = neol_d && (ny_d == YW'(SCR_H - 1));
  end

  // Snapshot of the whole screen on the accepting edge; contents need no reset.
  always_ff @(posedge clk) begin
    if (capture_s && !reset) begin
      for (int i = 0; i < NPIX; i++) begin
        shadow_q[i] <= screen_in[i*PIX_W +: PIX_W];
      end
    end
  end

  // Control FSM with all stream outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 8'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Requests arriving in LOAD or STREAM are counted, not queued.
      if (frame_req && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (frame_req) begin
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          data_q  <= shadow_q[AW'(0)];
          x_q     <= '0;
          y_q     <= '0;
          sof_q   <= 1'b1;
          eol_q   <= (SCR_W == 1);
          eof_q   <= (NPIX == 1);
          valid_q <= 1'b1;
          state_q <= S_STREAM;
        end
        S_STREAM: begin
          if (valid_q && pix.pix_ready) begin
            if (eof_q) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              sof_q   <= 1'b0;
              eol_q   <= 1'b0;
              eof_q   <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              data_q <= npix_d;
              x_q    <= nx_d;
              y_q    <= ny_d;
              sof_q  <= 1'b0;
              eol_q  <= neol_d;
              eof_q  <= neof_d;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign drop_count    = drop_q;
  assign pix.pix_valid = valid_q;
  assign pix.pix_data  = data_q;
  assign pix.pix_x     = x_q;
  assign pix.pix_y     = y_q;
  assign pix.pix_sof   = sof_q;
  assign pix.pix_eol   = eol_q;
  assign pix.pix_eof   = eof_q;

endmodule

// File: tb/tb_screen_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_screen_frame_streamer
//   Scoreboard bench: frame starts push the expected raster sequence, a
//   negedge monitor pops and compares on every transfer, checks stall
//   stability and the frame_done pulse.
// -----------------------------------------------------------------------------
module tb_screen_frame_streamer;
  localparam int W = 30;
  localparam int H = 30;
  localparam int P = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic             frame_req;
  logic [W*H*P-1:0] screen_in;
  logic             busy;
  logic             frame_done;
  logic [7:0]       drop_count;

  screen_frame_streamer_if #(.SCR_W(W), .SCR_H(H), .PIX_W(P)) pix_if ();

  screen_frame_streamer #(.SCR_W(W), .SCR_H(H), .PIX_W(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .screen_in  (screen_in),
    .frame_req  (frame_req),
    .busy       (busy),
    .frame_done (frame_done),
    .drop_count (drop_count),
    .pix        (pix_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] d;
    logic [4:0]  x;
    logic [4:0]  y;
    logic        sof;
    logic        eol;
    logic        eof;
  } pix_t;

  pix_t exp_q[$];
  pix_t stall_v;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_xfer = 0;
  bit   expect_done = 1'b0;
  bit   have_stall = 1'b0;
  bit   ready_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic pix_t cur_pix();
    pix_t c;
    c.d   = pix_if.pix_data;
    c.x   = pix_if.pix_x;
    c.y   = pix_if.pix_y;
    c.sof = pix_if.pix_sof;
    c.eol = pix_if.pix_eol;
    c.eof = pix_if.pix_eof;
    return c;
  endfunction

  task automatic set_screen(input logic [7:0] b);
    for (int x = 0; x < W; x++) begin
      for (int y = 0; y < H; y++) begin
        screen_in[(x*H+y)*P +: P] = {x[7:0], y[7:0], b};
      end
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    pix_t e;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        e.d   = {x[7:0], y[7:0], b};
        e.x   = x[4:0];
        e.y   = y[4:0];
        e.sof = (x == 0) && (y == 0);
        e.eol = (x == W - 1);
        e.eof = (x == W - 1) && (y == H - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Request a frame; optionally invert the screen right after capture and
  // check the two-cycle latency to the first pixel.
  task automatic start_frame(input logic [7:0] b, input bit inv, input bit lat);
    @(posedge clk); #1;
    push_frame(b);
    frame_req = 1'b1;
    @(posedge clk); #1;
    frame_req = 1'b0;
    if (inv) screen_in = ~screen_in;
    if (lat) begin
      check("lat_load", {62'd0, busy, pix_if.pix_valid}, 64'h2);
      @(posedge clk); #1;
      check("lat_first", {38'd0, pix_if.pix_valid, pix_if.pix_sof, pix_if.pix_data},
            {38'd0, 2'b11, 16'h0000, b});
    end
  endtask

  task automatic wait_done(input string name, output int cyc);
    bit found;
    found = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      cyc = i + 1;
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {63'd0, found}, 64'd1);
  endtask

  // Sink: ready either always high or roughly 30% duty.
  initial begin
    pix_if.pix_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      pix_if.pix_ready = ready_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Monitor: decisions here predict what the following rising edge does.
  always @(negedge clk) begin
    pix_t c;
    pix_t e;
    if (reset) begin
      expect_done = 1'b0;
      have_stall  = 1'b0;
    end else begin
      if (expect_done) begin
        check("frame_done_pulse", {63'd0, frame_done}, 64'd1);
        expect_done = 1'b0;
      end else if (frame_done) begin
        check("frame_done_spurious", {63'd0, frame_done}, 64'd0);
      end
      c = cur_pix();
      if (have_stall) begin
        check("stall_hold", {26'd0, pix_if.pix_valid, c}, {26'd0, 1'b1, stall_v});
      end
      have_stall = 1'b0;
      if (pix_if.pix_valid) begin
        if (pix_if.pix_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_pixel", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("pixel", 64'(c), 64'(e));
          end
          n_xfer++;
          if (c.eof) expect_done = 1'b1;
        end else begin
          stall_v    = c;
          have_stall = 1'b1;
        end
      end
    end
  end

  initial begin
    int cyc;
    int base;
    bit reached;
    reset     = 1'b1;
    frame_req = 1'b0;
    set_screen(8'hA5);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {16'd0, busy, frame_done, drop_count, pix_if.pix_valid, pix_if.pix_data,
                          pix_if.pix_x, pix_if.pix_y, pix_if.pix_sof, pix_if.pix_eol, pix_if.pix_eof},
          64'd0);
    reset = 1'b0;

    // Frame 1: basic, ready held high.
    ready_rand = 1'b0;
    start_frame(8'hA5, 1'b0, 1'b1);
    wait_done("f1_done", cyc);
    check("f1_cycles", 64'(cyc), 64'd900);
    check("f1_drop", {56'd0, drop_count}, 64'd0);
    check("f1_drained", 64'(exp_q.size()), 64'd0);

    // Frame 2: backpressure, snapshot isolation, three dropped requests.
    set_screen(8'h3C);
    ready_rand = 1'b1;
    start_frame(8'h3C, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      frame_req = 1'b1;
      @(posedge clk); #1;
      frame_req = 1'b0;
      repeat (5) @(posedge clk);
    end
    #1;
    check("drop_three", {56'd0, drop_count}, 64'd3);
    wait_done("f2_done", cyc);

    // Frame 3: requested in the frame_done cycle, then request held high.
    set_screen(8'h5A);
    ready_rand = 1'b0;
    push_frame(8'h5A);
    frame_req = 1'b1;
    @(posedge clk); #1;
    check("b2b_accept", {54'd0, busy, pix_if.pix_valid, drop_count}, {54'd0, 2'b10, 8'd3});
    @(posedge clk); #1;
    check("b2b_first", {62'd0, pix_if.pix_valid, pix_if.pix_sof}, 64'd3);
    repeat (298) @(posedge clk);
    #1;
    frame_req = 1'b0;
    check("drop_saturate", {56'd0, drop_count}, 64'd255);
    wait_done("f3_done", cyc);
    check("f3_drained", 64'(exp_q.size()), 64'd0);

    // Frame 4: reset after 100 transfers.
    set_screen(8'h11);
    start_frame(8'h11, 1'b0, 1'b0);
    base    = n_xfer;
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (n_xfer - base >= 100) begin
        reached = 1'b1;
        break;
      end
    end
    check("f4_100_xfers", {63'd0, reached}, 64'd1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("midreset_state", {16'd0, busy, frame_done, drop_count, pix_if.pix_valid, pix_if.pix_data,
                             pix_if.pix_x, pix_if.pix_y, pix_if.pix_sof, pix_if.pix_eol, pix_if.pix_eof},
          64'd0);
    reset = 1'b0;
    repeat (20) @(posedge clk);

    // Frame 5: fresh frame after reset streams from (0,0).
    set_screen(8'h77);
    ready_rand = 1'b1;
    start_frame(8'h77, 1'b0, 1'b1);
    wait_done("f5_done", cyc);
    check("f5_drop", {56'd0, drop_count}, 64'd0);
    check("f5_drained", 64'(exp_q.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
